eth_tx_frame_arbiter: RTL and testbench
=======================================

// Module: eth_tx_frame_arbiter
// PURPOSE
//  Frame-granular round-robin arbiter sharing the 1G MAC TX AXI-stream input among PORTS requesters.
//  Sits in the tx_clk domain directly upstream of the MAC tx_axis_* port.
//  Holds a grant for a whole frame (until tlast); enforces a max-frame-length watchdog that truncates runaway frames.
// PARAMETERS
//  PORTS          2     number of requesters, 2..4
//  MAX_FRAME_LEN  1522  max beats per frame before forced truncation, >=2
// PORTS
//  tx_clk            in   1        MAC TX clock; sole clock
//  tx_rst_n          in   1        asynchronous active-low reset
//  s_axis_tdata      in   PORTS*8  requester data, port i at [8*i+7:8*i]
//  s_axis_tvalid     in   PORTS    requester valid
//  s_axis_tready     out  PORTS    requester ready
//  s_axis_tlast      in   PORTS    requester end of frame
//  s_axis_tuser      in   PORTS    requester frame error flag
//  m_axis_tdata      out  8        to MAC tx_axis_tdata
//  m_axis_tvalid     out  1        to MAC tx_axis_tvalid
//  m_axis_tready     in   1        from MAC tx_axis_tready
//  m_axis_tlast      out  1        to MAC tx_axis_tlast
//  m_axis_tuser      out  1        to MAC tx_axis_tuser
//  port_en           in   PORTS    per-port arbitration enable
//  grant_idx         out  2        port currently or last granted
//  busy              out  1        1 while in PASS or DROP
//  frame_done        out  1        1-cycle pulse on accepted m_axis_tlast beat
//  frame_truncated   out  1        1-cycle pulse when watchdog truncates
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, last_grant=PORTS-1 (port 0 wins first), beat_cnt=0.
//  States: IDLE, PASS, DROP. Handshake = tvalid & tready, same cycle.
//  IDLE: req = s_axis_tvalid & port_en. If req!=0, select first set bit scanning last_grant+1 upward, wrapping
//   modulo PORTS; register grant_idx, enter PASS next edge. Arbitration latency 1 cycle; no s_axis_tready in IDLE.
//  PASS (g=grant_idx): m_axis_tdata/tvalid/tlast/tuser = port g inputs, combinationally; s_axis_tready[g]=m_axis_tready,
//   others 0. Outputs tdata/tlast/tuser forced 0 when m_axis_tvalid=0.
//   beat_cnt increments per m handshake; width clog2(MAX_FRAME_LEN+1), never wraps.
//   Handshake with tlast=1: frame_done=1, last_grant=g, beat_cnt=0, -> IDLE.
//   Handshake where beat_cnt==MAX_FRAME_LEN-1 and source tlast=0: m_axis_tlast=1, m_axis_tuser=1 forced,
//   frame_done=1, frame_truncated=1, -> DROP.
//   Exactly MAX_FRAME_LEN beats with tlast on the last is legal: no truncation.
//  DROP: m_axis_tvalid=0; s_axis_tready[g]=1; discard beats until source tlast handshake; then last_grant=g -> IDLE.
//  port_en deassert mid-frame does not abort the granted frame; only masks next arbitration.
//  Source tvalid drop mid-frame: m_axis_tvalid follows; grant held (no timeout).
//  Reset mid-frame: immediate return to IDLE; partial frame abandoned; MAC underflow handling is upstream's concern.
//  busy = (state!=IDLE). grant_idx holds value in IDLE.
// TESTING
//  1 PORTS=2; both ports present 4-beat frames at cycle 0 -> port0 frame out first, then port1, no idle beats within a frame.
//  2 Both ports stream 3 back-to-back frames -> output order 0,1,0,1,0,1; frame_done pulses 6 times.
//  3 MAX_FRAME_LEN=64; port0 sends 69-beat frame -> 64 beats out, beat 64 tlast=1,tuser=1; frame_truncated=1 once; 5 beats drained; next frame normal.
//  4 10-beat frame with m_axis_tready random 50% -> 10 beats bit-exact, tlast only on beat 10, s_tready mirrors m_tready.
//  5 port_en=2'b10 with both requesting -> only port1 served; set port_en=2'b11 mid-frame -> port1 frame completes, then port0.
//  6 Assert tx_rst_n=0 at beat 3 of a frame -> all outputs 0 same cycle; after release port0 wins fresh arbitration.

Source files
------------

// File: rtl/eth_tx_frame_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_frame_arbiter_if
// Description : Byte-wide AXI-stream bundle with LANES parallel lanes.
//               One instance carries all requester streams into the arbiter.
//               A single-lane instance carries the merged stream to the MAC.
// Revision    : 1.0 - initial release
// ============================================================================
interface eth_tx_frame_arbiter_if #(
    parameter int LANES = 1
);
    logic [LANES*8-1:0] tdata;
    logic [LANES-1:0]   tvalid;
    logic [LANES-1:0]   tready;
    logic [LANES-1:0]   tlast;
    logic [LANES-1:0]   tuser;

    // Source side: drives payload and framing, receives back-pressure
    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    // Sink side: receives payload and framing, drives back-pressure
    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/eth_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_frame_arbiter
// Description : Frame-granular round-robin arbiter feeding the 1G MAC TX
//               AXI-stream input from PORTS requesters. A grant is held for a
//               whole frame; a beat-count watchdog cuts runaway frames short,
//               marks the cut beat as errored and drains the remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_frame_arbiter #(
    parameter int PORTS         = 2,
    parameter int MAX_FRAME_LEN = 1522
) (
    input  logic                   tx_clk,
    input  logic                   tx_rst_n,
    eth_tx_frame_arbiter_if.slave  s_axis,
    eth_tx_frame_arbiter_if.master m_axis,
    input  logic [PORTS-1:0]       port_en,
    output logic [1:0]             grant_idx,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   frame_truncated
);

    // Counter is wide enough to hold MAX_FRAME_LEN; it never passes the last
    // legal beat index because the frame is closed or cut there.
    localparam int                 c_CNT_W     = $clog2(MAX_FRAME_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(MAX_FRAME_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [1:0]         c_RST_LAST  = 2'(PORTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         last_grant_q, last_grant_d;
    logic [c_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [PORTS-1:0]   w_req;
    logic [PORTS-1:0]   w_sel;
    logic [PORTS-1:0]   w_s_ready;
    logic               w_pick_found;
    logic [1:0]         w_pick;
    logic [1:0]         w_cand;

    logic               w_src_valid;
    logic               w_src_last;
    logic               w_src_user;
    logic [7:0]         w_src_data;

    logic               w_at_limit;
    logic               w_m_valid;
    logic               w_m_last;
    logic               w_m_user;
    logic [7:0]         w_m_data;
    logic               w_done;
    logic               w_trunc;

    // Round-robin pick: first enabled requester after the port served last
    always_comb begin
        w_req        = s_axis.tvalid & port_en;
        w_pick_found = 1'b0;
        w_pick       = last_grant_q;
        w_cand       = last_grant_q;
        for (int k = 1; k <= PORTS; k++) begin
            w_cand = 2'((int'(last_grant_q) + k) % PORTS);
            for (int i = 0; i < PORTS; i++) begin
                if (!w_pick_found && (w_cand == 2'(i)) && w_req[i]) begin
                    w_pick_found = 1'b1;
                    w_pick       = w_cand;
                end
            end
        end
    end

    // Select the granted requester's lane onto the internal source signals
    always_comb begin
        w_sel       = '0;
        w_src_valid = 1'b0;
        w_src_last  = 1'b0;
        w_src_user  = 1'b0;
        w_src_data  = 8'h00;
        for (int i = 0; i < PORTS; i++) begin
            if (grant_q == 2'(i)) begin
                w_sel[i]    = 1'b1;
                w_src_valid = s_axis.tvalid[i];
                w_src_last  = s_axis.tlast[i];
                w_src_user  = s_axis.tuser[i];
                w_src_data  = s_axis.tdata[8*i +: 8];
            end
        end
    end

    // Next-state and output decode for IDLE / PASS / DROP
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        w_s_ready    = '0;
        w_m_valid    = 1'b0;
        w_m_last     = 1'b0;
        w_m_user     = 1'b0;
        w_m_data     = 8'h00;
        w_done       = 1'b0;
        w_trunc      = 1'b0;
        w_at_limit   = (beat_cnt_q == c_LAST_BEAT);

        case (state_q)
            ST_IDLE: begin
                // Grant is registered; the winner is served from the next cycle
                if (w_pick_found) begin
                    grant_d = w_pick;
                    state_d = ST_PASS;
                end
            end

            ST_PASS: begin
                w_m_valid = w_src_valid;
                w_s_ready = w_sel & {PORTS{m_axis.tready[0]}};
                // Payload is zeroed while invalid so the MAC never sees stale lanes.
                // The final allowed beat of an unterminated frame is closed and
                // flagged bad so the MAC aborts it.
                if (w_src_valid) begin
                    w_m_data = w_src_data;
                    w_m_last = w_src_last | w_at_limit;
                    w_m_user = w_src_user | (w_at_limit & ~w_src_last);
                end
                if (w_src_valid && m_axis.tready[0]) begin
                    if (w_src_last) begin
                        w_done       = 1'b1;
                        last_grant_d = grant_q;
                        beat_cnt_d   = '0;
                        state_d      = ST_IDLE;
                    end else if (w_at_limit) begin
                        w_done     = 1'b1;
                        w_trunc    = 1'b1;
                        beat_cnt_d = '0;
                        state_d    = ST_DROP;
                    end else begin
                        beat_cnt_d = beat_cnt_q + c_CNT_ONE;
                    end
                end
            end

            ST_DROP: begin
                // Swallow the rest of the cut frame without forwarding it
                w_s_ready = w_sel;
                if (w_src_valid && w_src_last) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant and beat counter registers
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= c_RST_LAST;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign s_axis.tready   = w_s_ready;
    assign m_axis.tvalid   = w_m_valid;
    assign m_axis.tdata    = w_m_data;
    assign m_axis.tlast    = w_m_last;
    assign m_axis.tuser    = w_m_user;
    assign grant_idx       = grant_q;
    assign busy            = (state_q != ST_IDLE);
    assign frame_done      = w_done;
    assign frame_truncated = w_trunc;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_tx_frame_arbiter
// Description : Self-checking bench for eth_tx_frame_arbiter (2 ports,
//               64-beat frame limit). Requester frames live in per-port
//               queues; a transaction-level model of ownership predicts every
//               output each cycle, and per-scenario literals pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_tx_frame_arbiter;

    localparam int PORTS  = 2;
    localparam int MAXLEN = 64;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    logic             tx_clk   = 1'b0;
    logic             tx_rst_n = 1'b0;
    logic [PORTS-1:0] port_en;
    logic [1:0]       grant_idx;
    logic             busy;
    logic             frame_done;
    logic             frame_truncated;

    eth_tx_frame_arbiter_if #(.LANES(PORTS)) s_if ();
    eth_tx_frame_arbiter_if #(.LANES(1))     m_if ();

    eth_tx_frame_arbiter #(
        .PORTS         (PORTS),
        .MAX_FRAME_LEN (MAXLEN)
    ) dut (
        .tx_clk          (tx_clk),
        .tx_rst_n        (tx_rst_n),
        .s_axis          (s_if),
        .m_axis          (m_if),
        .port_en         (port_en),
        .grant_idx       (grant_idx),
        .busy            (busy),
        .frame_done      (frame_done),
        .frame_truncated (frame_truncated)
    );

    always #5 tx_clk = ~tx_clk;

    // Pending beats of each requester, head is what the port presents now
    beat_t srcq [PORTS][$];

    // Model: who owns the MAC stream (-1 = nobody), whether the rest of the
    // owner's frame is being discarded, beats already forwarded, fairness pointer
    int  m_owner, m_last, m_beats, m_grant;
    bit  m_drop;
    bit  rnd_ready;

    // Per-scenario observations
    int  order_enc;            // model frame completion order, digits after a leading 1
    int  d_beats, d_done, d_trunc, d_lasts, d_last_at;
    int  d_b64_flag;

    int  n_vec, n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_drop  = 1'b0;
        m_beats = 0;
        m_last  = PORTS - 1;
        m_grant = 0;
    endtask

    task automatic clear_stats();
        order_enc  = 1;
        d_beats    = 0;
        d_done     = 0;
        d_trunc    = 0;
        d_lasts    = 0;
        d_last_at  = 0;
        d_b64_flag = 0;
    endtask

    task automatic add_frame(input int p, input int n, input int tag, input bit user);
        beat_t x;
        for (int b = 0; b < n; b++) begin
            x.d = 8'(p * 128 + tag * 16 + b);
            x.l = (b == n - 1);
            x.u = user & (b == n - 1);
            srcq[p].push_back(x);
        end
    endtask

    task automatic drive_inputs();
        logic [PORTS*8-1:0] d;
        logic [PORTS-1:0]   v, l, u;
        d = '0; v = '0; l = '0; u = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (srcq[p].size() > 0) begin
                v[p]       = 1'b1;
                d[8*p +: 8] = srcq[p][0].d;
                l[p]       = srcq[p][0].l;
                u[p]       = srcq[p][0].u;
            end
        end
        s_if.tdata  = d;
        s_if.tvalid = v;
        s_if.tlast  = l;
        s_if.tuser  = u;
        m_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // One cycle after the negedge: present inputs, predict, compare, advance
    task automatic step();
        int         e_valid, e_data, e_last, e_user, e_sready, e_done, e_trunc;
        int         n_owner, n_last, n_beats, n_grant, cand, o;
        bit         n_drop, final_slot, rdy;
        logic [PORTS-1:0] take;

        drive_inputs();
        #1;
        rdy = m_if.tready[0];

        e_valid = 0; e_data = 0; e_last = 0; e_user = 0;
        e_sready = 0; e_done = 0; e_trunc = 0;
        take = '0;
        n_owner = m_owner; n_last = m_last; n_beats = m_beats;
        n_grant = m_grant; n_drop = m_drop;
        o = m_owner;

        if (m_owner < 0) begin
            for (int k = 1; k <= PORTS; k++) begin
                cand = (m_last + k) % PORTS;
                if (n_owner < 0 && s_if.tvalid[cand] && port_en[cand]) begin
                    n_owner = cand;
                    n_grant = cand;
                end
            end
        end else if (!m_drop) begin
            // This beat would be the MAXLEN-th of the frame
            final_slot = (m_beats + 1 == MAXLEN);
            if (s_if.tvalid[o]) begin
                e_valid = 1;
                e_data  = int'(s_if.tdata[8*o +: 8]);
                e_last  = int'(s_if.tlast[o] | final_slot);
                e_user  = int'(s_if.tuser[o] | (final_slot & ~s_if.tlast[o]));
            end
            e_sready = rdy ? (1 << o) : 0;
            if (s_if.tvalid[o] && rdy) begin
                take[o] = 1'b1;
                if (s_if.tlast[o]) begin
                    e_done    = 1;
                    n_owner   = -1;
                    n_last    = o;
                    n_beats   = 0;
                    order_enc = order_enc * 10 + o;
                end else if (final_slot) begin
                    e_done    = 1;
                    e_trunc   = 1;
                    n_drop    = 1'b1;
                    n_beats   = 0;
                    order_enc = order_enc * 10 + o;
                end else begin
                    n_beats = m_beats + 1;
                end
            end
        end else begin
            e_sready = 1 << o;
            if (s_if.tvalid[o]) begin
                take[o] = 1'b1;
                if (s_if.tlast[o]) begin
                    n_owner = -1;
                    n_drop  = 1'b0;
                    n_last  = o;
                end
            end
        end

        chk("m_tvalid", 32'(m_if.tvalid), 32'(e_valid));
        chk("m_tdata",  32'(m_if.tdata),  32'(e_data));
        chk("m_tlast",  32'(m_if.tlast),  32'(e_last));
        chk("m_tuser",  32'(m_if.tuser),  32'(e_user));
        chk("s_tready", 32'(s_if.tready), 32'(e_sready));
        chk("busy",     32'(busy),        32'(m_owner >= 0));
        chk("grant_idx", 32'(grant_idx),  32'(m_grant));
        chk("frame_done", 32'(frame_done), 32'(e_done));
        chk("frame_truncated", 32'(frame_truncated), 32'(e_trunc));

        if (m_if.tvalid[0] && m_if.tready[0]) begin
            d_beats++;
            if (m_if.tlast[0]) begin
                d_lasts++;
                d_last_at = d_beats;
            end
            if (d_beats == MAXLEN)
                d_b64_flag = int'(m_if.tlast[0] & m_if.tuser[0]);
        end
        if (frame_done)      d_done++;
        if (frame_truncated) d_trunc++;

        for (int p = 0; p < PORTS; p++)
            if (take[p]) void'(srcq[p].pop_front());

        m_owner = n_owner; m_last = n_last; m_beats = n_beats;
        m_grant = n_grant; m_drop = n_drop;
    endtask

    task automatic cycle();
        @(negedge tx_clk);
        step();
    endtask

    function automatic bit all_empty();
        for (int p = 0; p < PORTS; p++)
            if (srcq[p].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((!all_empty() || m_owner >= 0) && n < budget) begin
            cycle();
            n++;
        end
        n_vec++;
        if (!all_empty() || m_owner >= 0) begin
            n_bad++;
            $display("FAIL %s drain_timeout: still busy after %0d cycles, expected idle", name, n);
        end
    endtask

    // Assert reset in the middle of a cycle and require every output low at once
    task automatic reset_check(input string name);
        @(negedge tx_clk);
        drive_inputs();
        tx_rst_n = 1'b0;
        #1;
        chk({name, "_m_tvalid"}, 32'(m_if.tvalid), 32'd0);
        chk({name, "_m_tdata"},  32'(m_if.tdata),  32'd0);
        chk({name, "_m_tlast"},  32'(m_if.tlast),  32'd0);
        chk({name, "_m_tuser"},  32'(m_if.tuser),  32'd0);
        chk({name, "_s_tready"}, 32'(s_if.tready), 32'd0);
        chk({name, "_busy"},     32'(busy),        32'd0);
        chk({name, "_grant"},    32'(grant_idx),   32'd0);
        chk({name, "_done"},     32'(frame_done),  32'd0);
        chk({name, "_trunc"},    32'(frame_truncated), 32'd0);
        model_reset();
    endtask

    task automatic release_reset();
        @(negedge tx_clk);
        tx_rst_n = 1'b1;
        step();
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rnd_ready = 1'b0;
        port_en   = 2'b11;
        model_reset();
        clear_stats();
        s_if.tdata = '0; s_if.tvalid = '0; s_if.tlast = '0; s_if.tuser = '0;
        m_if.tready = 1'b1;

        // Both ports present 4-beat frames while still in reset, then go
        add_frame(0, 4, 1, 1'b0);
        add_frame(1, 4, 1, 1'b0);
        repeat (2) @(negedge tx_clk);
        reset_check("por");
        release_reset();
        drain("t1", 100);
        chk("t1_order",  32'(order_enc), 32'd101);
        chk("t1_beats",  32'(d_beats),   32'd8);
        chk("t1_done",   32'(d_done),    32'd2);

        // Three back-to-back frames per port must alternate
        clear_stats();
        add_frame(0, 3, 2, 1'b0); add_frame(0, 5, 3, 1'b0); add_frame(0, 2, 4, 1'b0);
        add_frame(1, 3, 2, 1'b0); add_frame(1, 5, 3, 1'b0); add_frame(1, 2, 4, 1'b0);
        drain("t2", 200);
        chk("t2_order", 32'(order_enc), 32'd1010101);
        chk("t2_done",  32'(d_done),    32'd6);
        chk("t2_beats", 32'(d_beats),   32'd20);

        // Runaway 69-beat frame is cut at 64; a normal frame follows
        clear_stats();
        add_frame(0, 69, 5, 1'b0);
        add_frame(0, 4, 6, 1'b0);
        drain("t3", 300);
        chk("t3_order",  32'(order_enc),  32'd100);
        chk("t3_trunc",  32'(d_trunc),    32'd1);
        chk("t3_done",   32'(d_done),     32'd2);
        chk("t3_beats",  32'(d_beats),    32'd68);
        chk("t3_lasts",  32'(d_lasts),    32'd2);
        chk("t3_cut_lu", 32'(d_b64_flag), 32'd1);

        // 10-beat frame with a stalling MAC, errored frame flag carried through
        clear_stats();
        rnd_ready = 1'b1;
        add_frame(0, 10, 7, 1'b1);
        drain("t4", 200);
        rnd_ready = 1'b0;
        chk("t4_beats",   32'(d_beats),   32'd10);
        chk("t4_lasts",   32'(d_lasts),   32'd1);
        chk("t4_last_at", 32'(d_last_at), 32'd10);
        chk("t4_trunc",   32'(d_trunc),   32'd0);

        // Port 0 masked; unmasking mid-frame does not disturb port 1's frame
        clear_stats();
        port_en = 2'b10;
        add_frame(0, 6, 8, 1'b0);
        add_frame(1, 6, 8, 1'b0);
        repeat (4) cycle();
        port_en = 2'b11;
        drain("t5", 100);
        chk("t5_order", 32'(order_enc), 32'd110);
        chk("t5_done",  32'(d_done),    32'd2);

        // Reset during port 1's frame, then port 0 must win fresh arbitration
        clear_stats();
        add_frame(1, 8, 9, 1'b0);
        begin
            int n;
            n = 0;
            while (m_beats != 3 && n < 20) begin
                cycle();
                n++;
            end
            n_vec++;
            if (m_beats != 3) begin
                n_bad++;
                $display("FAIL t6_reach_beat3: beats %0d, expected 3", m_beats);
            end
        end
        reset_check("t6");
        for (int p = 0; p < PORTS; p++) srcq[p].delete();
        clear_stats();
        add_frame(0, 4, 10, 1'b0);
        add_frame(1, 4, 10, 1'b0);
        @(negedge tx_clk);
        release_reset();
        drain("t6", 100);
        chk("t6_order", 32'(order_enc), 32'd101);
        chk("t6_done",  32'(d_done),    32'd2);
        chk("t6_beats", 32'(d_beats),   32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
